// File: rtl/des_subkey_sequencer.sv
// DES key schedule sequencer: PC-1 on load, per-round C/D rotation, PC-2 out.
// Streams K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_subkey_sequencer #(
    parameter int unsigned PARITY_CHECK = 32'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [63:0] Key,
    input  logic        Decrypt,
    input  logic        Subkey_ready,
    output logic [47:0] Subkey,
    output logic        Subkey_valid,
    output logic [3:0]  Round,
    output logic        Busy,
    output logic        Done,
    output logic        Parity_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Table entries are 1-based DES bit numbers, first entry in the MSBs.
    localparam logic [335:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [287:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        int          idx;
        r = 56'd0;
        for (int i = 0; i < 56; i++) begin
            idx       = 64 - int'(PC1_TAB[(55 - i) * 6 +: 6]);
            r[55 - i] = k[idx];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        int          idx;
        r = 48'd0;
        for (int i = 0; i < 48; i++) begin
            idx       = 56 - int'(PC2_TAB[(47 - i) * 6 +: 6]);
            r[47 - i] = cd[idx];
        end
        return r;
    endfunction

    // SH[n] for n = 1..16; anything else means no rotation.
    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        logic [1:0] r;
        case (n)
            5'd1, 5'd2, 5'd9, 5'd16: r = 2'd1;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {x[26:0], x[27]};
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {x[0], x[27:1]};
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    // DES keys carry odd parity per byte; any even byte is flagged.
    function automatic logic parity_bad(input logic [63:0] k);
        logic r;
        r = 1'b0;
        for (int b = 0; b < 8; b++) begin
            r = r | ~(^k[b * 8 +: 8]);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        perr_q, perr_d;

    logic [55:0] pc1_s;
    logic [1:0]  sh_enc_s, sh_dec_s;

    assign pc1_s    = pc1(Key);
    assign sh_enc_s = shift_amt({1'b0, round_q} + 5'd2);
    assign sh_dec_s = shift_amt(5'd16 - {1'b0, round_q});

    // State and key-schedule registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic: load on Start, rotate on each accepted subkey.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        perr_d  = perr_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d  = Decrypt;
                    perr_d  = (PARITY_CHECK != 32'd0) ? parity_bad(Key) : 1'b0;
                    round_d = 4'd0;
                    state_d = S_GEN;
                    // Decrypt starts from C0/D0, which equals C16/D16.
                    if (Decrypt) begin
                        c_d = pc1_s[55:28];
                        d_d = pc1_s[27:0];
                    end else begin
                        c_d = rotl(pc1_s[55:28], 2'd1);
                        d_d = rotl(pc1_s[27:0], 2'd1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GEN: begin
                if (Subkey_ready) begin
                    if (mode_q) begin
                        c_d = rotr(c_q, sh_dec_s);
                        d_d = rotr(d_q, sh_dec_s);
                    end else begin
                        c_d = rotl(c_q, sh_enc_s);
                        d_d = rotl(d_q, sh_enc_s);
                    end
                    if (round_q == 4'd15) begin
                        round_d = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_GEN;
                    end
                end else begin
                    state_d = S_GEN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Subkey_valid = (state_q == S_GEN);
    assign Subkey       = Subkey_valid ? pc2({c_q, d_q}) : 48'd0;
    assign Round        = round_q;
    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign Parity_err   = perr_q;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Directed bench for des_subkey_sequencer using the classic 133457799BBCDFF1
// schedule; one instance without and one with the parity checker.
module tb_des_subkey_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [63:0] Key;
    logic        Decrypt;
    logic        Subkey_ready;

    logic [47:0] Subkey,  Subkey_p;
    logic        Subkey_valid, Subkey_valid_p;
    logic [3:0]  Round,   Round_p;
    logic        Busy,    Busy_p;
    logic        Done,    Done_p;
    logic        Parity_err, Parity_err_p;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    logic [47:0] ks [16];
    int n_cmp = 0;
    int n_err = 0;

    des_subkey_sequencer #(.PARITY_CHECK(0)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Key(Key), .Decrypt(Decrypt),
        .Subkey_ready(Subkey_ready), .Subkey(Subkey), .Subkey_valid(Subkey_valid),
        .Round(Round), .Busy(Busy), .Done(Done), .Parity_err(Parity_err)
    );

    des_subkey_sequencer #(.PARITY_CHECK(1)) u_dut_par (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Key(Key), .Decrypt(Decrypt),
        .Subkey_ready(Subkey_ready), .Subkey(Subkey_p), .Subkey_valid(Subkey_valid_p),
        .Round(Round_p), .Busy(Busy_p), .Done(Done_p), .Parity_err(Parity_err_p)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start edge, then scramble Key/Decrypt to prove they are not re-sampled.
    task automatic start_sched(input logic [63:0] k, input logic dec);
        Key     = k;
        Decrypt = dec;
        Start   = 1'b1;
        step();
        Start   = 1'b0;
        Key     = KEY_B;
        Decrypt = ~dec;
    endtask

    task automatic run_sched(input logic dec, input logic zero, input int stall_at,
                             input int stall_len, input logic inject);
        logic [47:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = zero ? 48'd0 : ks[dec ? 15 - i : i];
            chk($sformatf("subkey r%0d", i), {16'd0, Subkey}, {16'd0, exp});
            chk($sformatf("subkey_par r%0d", i), {16'd0, Subkey_p}, {16'd0, exp});
            chk($sformatf("round r%0d", i), {60'd0, Round}, i);
            chk($sformatf("valid r%0d", i), {63'd0, Subkey_valid}, 64'd1);
            chk($sformatf("busy r%0d", i), {63'd0, Busy}, 64'd1);
            chk($sformatf("done r%0d", i), {63'd0, Done}, 64'd0);
            if (inject && i == 7) begin
                Start = 1'b1;
                Key   = KEY_B;
            end
            if (i == stall_at) begin
                Subkey_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk($sformatf("stall subkey s%0d", s), {16'd0, Subkey}, {16'd0, exp});
                    chk($sformatf("stall round s%0d", s), {60'd0, Round}, i);
                    chk($sformatf("stall done s%0d", s), {63'd0, Done}, 64'd0);
                end
                Subkey_ready = 1'b1;
            end
            step();
            Start = 1'b0;
        end
        chk("done pulse", {63'd0, Done}, 64'd1);
        chk("done valid", {63'd0, Subkey_valid}, 64'd0);
        chk("done subkey", {16'd0, Subkey}, 64'd0);
        chk("done busy", {63'd0, Busy}, 64'd1);
        if (inject) begin
            Start = 1'b1;
            Key   = KEY_B;
        end
        step();
        Start = 1'b0;
        chk("idle done", {63'd0, Done}, 64'd0);
        chk("idle busy", {63'd0, Busy}, 64'd0);
        chk("idle round", {60'd0, Round}, 64'd0);
        chk("idle valid", {63'd0, Subkey_valid}, 64'd0);
        if (inject) begin
            step();
            chk("start in done ignored", {63'd0, Busy}, 64'd0);
        end
    endtask

    initial begin
        ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        Reset        = 1'b1;
        Start        = 1'b0;
        Key          = 64'd0;
        Decrypt      = 1'b0;
        Subkey_ready = 1'b1;
        #12;
        chk("reset subkey", {16'd0, Subkey}, 64'd0);
        chk("reset valid", {63'd0, Subkey_valid}, 64'd0);
        chk("reset round", {60'd0, Round}, 64'd0);
        chk("reset busy", {63'd0, Busy}, 64'd0);
        chk("reset done", {63'd0, Done}, 64'd0);
        chk("reset perr", {63'd0, Parity_err_p}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        step();

        // Encrypt, back-to-back
        start_sched(KEY_A, 1'b0);
        chk("perr keyA", {63'd0, Parity_err_p}, 64'd0);
        chk("perr off keyA", {63'd0, Parity_err}, 64'd0);
        run_sched(1'b0, 1'b0, -1, 0, 1'b0);

        // Decrypt
        start_sched(KEY_A, 1'b1);
        run_sched(1'b1, 1'b0, -1, 0, 1'b0);

        // Encrypt with 5-cycle stall at round 3
        start_sched(KEY_A, 1'b0);
        run_sched(1'b0, 1'b0, 3, 5, 1'b0);

        // Encrypt with ignored Start pulses at round 7 and during DONE
        start_sched(KEY_A, 1'b0);
        run_sched(1'b0, 1'b0, -1, 0, 1'b1);

        // Reset at round 9
        start_sched(KEY_A, 1'b0);
        for (int i = 0; i < 9; i++) step();
        chk("pre-reset round", {60'd0, Round}, 64'd9);
        chk("pre-reset subkey", {16'd0, Subkey}, {16'd0, ks[9]});
        #2 Reset = 1'b1;
        #1;
        chk("abort subkey", {16'd0, Subkey}, 64'd0);
        chk("abort valid", {63'd0, Subkey_valid}, 64'd0);
        chk("abort round", {60'd0, Round}, 64'd0);
        chk("abort busy", {63'd0, Busy}, 64'd0);
        chk("abort done", {63'd0, Done}, 64'd0);
        #2 Reset = 1'b0;
        step();
        chk("post-reset done", {63'd0, Done}, 64'd0);
        chk("post-reset busy", {63'd0, Busy}, 64'd0);
        start_sched(KEY_A, 1'b0);
        run_sched(1'b0, 1'b0, -1, 0, 1'b0);

        // All-zero key: even parity on every byte, all subkeys zero
        start_sched(64'd0, 1'b0);
        chk("perr zero key", {63'd0, Parity_err_p}, 64'd1);
        chk("perr off zero key", {63'd0, Parity_err}, 64'd0);
        run_sched(1'b0, 1'b1, -1, 0, 1'b0);
        chk("perr held", {63'd0, Parity_err_p}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_subkey_sequencer.md
Name: des_subkey_sequencer

Overview:
- Self-sequencing DES key schedule: accepts a 64-bit key on a Start pulse, applies PC-1, rotates C/D per round, applies PC-2, and streams the 16 round subkeys (48-bit), one per accepted cycle.
- Sits directly downstream of the key-load path and upstream of the round datapath, which consumes subkeys via a valid/ready handshake.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) without storing all subkeys.

Parameters:
- PARITY_CHECK, 0, when 1 the odd-parity checker on the key bytes is enabled and Parity_err is driven; when 0, Parity_err is tied 0.

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  single-cycle request to begin a schedule; ignored while Busy=1
- Key  input  64  DES key; bit 63 = DES bit 1; sampled only on an accepted Start
- Decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with Key
- Subkey_ready  input  1  consumer accepts the current Subkey this cycle
- Subkey  output  48  current round subkey; bit 47 = PC-2 bit 1; 0 when Subkey_valid=0
- Subkey_valid  output  1  Subkey is meaningful
- Round  output  4  consumer round index 0..15 of the current Subkey; 0 when idle
- Busy  output  1  schedule in progress (states GEN, DONE)
- Done  output  1  one-cycle pulse after the 16th subkey is accepted
- Parity_err  output  1  registered with Key; 1 if any key byte has even parity (PARITY_CHECK=1 only)

Behaviour:
- Reset values: state IDLE, C=D=0, Round=0, Subkey=0, Subkey_valid=0, Busy=0, Done=0, Parity_err=0, mode=0. Reset mid-schedule aborts immediately; no Done pulse.
- Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Left rotations in encrypt mode, right rotations in decrypt mode; each rotation is on the 28-bit C and D halves independently.
- State IDLE:
  - Start=1 at an edge latches mode=Decrypt and Parity_err.
  - Encrypt: loads C/D = PC-1(Key) rotated left by 1, giving C1/D1.
  - Decrypt: loads C/D = PC-1(Key) unrotated, giving C0/D0 = C16/D16.
  - Round=0, go to GEN.
- State GEN:
  - Subkey_valid=1 and Subkey = PC-2(C,D), combinational from the C/D registers.
  - Latency: first subkey is visible in the cycle after the Start edge.
  - On an edge with Subkey_ready=1:
    - If Round=15, go to DONE.
    - Otherwise Round increments.
    - Encrypt: C/D rotate left by SH[Round+2].
    - Decrypt: C/D rotate right by SH[16-Round].
  - Subkey_ready=0: all state holds and Subkey stays stable (stall of any length).
- State DONE: Subkey_valid=0, Done=1 for exactly one cycle, Busy=1, then go to IDLE. Round returns to 0.
- Throughput: with Subkey_ready held at 1, the 16 subkeys take 16 consecutive cycles and Done is high in the 17th cycle after the Start edge. A new Start is accepted in the cycle after DONE (IDLE).
- Start while Busy=1 (including during DONE) is ignored; Key and Decrypt changes during Busy have no effect.
- At the end of the schedule the accumulated rotation is 28 in both modes, so C/D equal C0/D0 in DONE.
- Parity_err is informational only; the schedule runs regardless.

Test Plan:
- Encrypt, Key=0x133457799BBCDFF1, Decrypt=0, Subkey_ready=1 -> cycle+1: Subkey=0x1B02EFFC7072, Round=0; cycle+2: 0x79AED9DBC9E5, Round=1; cycle+16: 0xCB3D8B0E17F5, Round=15; cycle+17: Done=1, Subkey_valid=0.
- Decrypt, same key -> first Subkey=0xCB3D8B0E17F5 (Round=0), last Subkey=0x1B02EFFC7072 (Round=15); reversed sequence equals the encrypt run exactly.
- Stall: deassert Subkey_ready for 5 cycles at Round=3 -> Subkey/Round hold unchanged; the sequence resumes with no skipped or duplicated subkey; Done is delayed by 5 cycles.
- Start pulses with a different Key at Round=7 and again during DONE -> ignored; the output sequence matches the original key; Busy stays 1 until IDLE.
- Assert Reset at Round=9 -> all outputs 0 in the same cycle, no Done; a subsequent Start with the same key reproduces the sequence from K1.
- PARITY_CHECK=1, Key=0x133457799BBCDFF1 (odd parity) -> Parity_err=0; Key=0x0000000000000000 -> Parity_err=1 and the 16 subkeys are all 0.
